// File: rtl/mmio_reg_bank_if.sv
// mmio_reg_bank_if: MMIO read/write request bus between the hal (master) and a register bank (slave).
interface mmio_reg_bank_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_err;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data, rd_valid, rd_err);
    modport slave (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data, rd_valid, rd_err);
endinterface

// File: rtl/mmio_reg_bank.sv
// mmio_reg_bank: windowed MMIO register bank with read/write, pulse and W1C registers and a fixed-latency read pipe.
module mmio_reg_bank #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 'h50,
    parameter int                    NUM_REGS    = 8,
    parameter int                    RD_LATENCY  = 1,
    parameter logic [NUM_REGS-1:0]   PULSE_MASK  = '0,
    parameter logic [NUM_REGS-1:0]   W1C_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mmio_reg_bank_if.slave                 bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_set_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]            wr_strobe_o
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, START_ADDR} + (ADDR_WIDTH+1)'(NUM_REGS);
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_num_err
        $error("NUM_REGS must be in 1..64");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_err
        $error("RD_LATENCY must be in 1..4");
    end
    if ((PULSE_MASK & W1C_MASK) != '0) begin : g_mask_err
        $error("PULSE_MASK and W1C_MASK overlap");
    end
    if (WIN_END[ADDR_WIDTH]) begin : g_win_err
        $error("register window reaches the end of the address space");
    end
    logic                                  rd_hit, wr_hit;
    logic [IW-1:0]                         rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0]                 rd_val;
    logic [DATA_WIDTH-1:0]                 reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]                 reg_d [NUM_REGS];
    logic [NUM_REGS-1:0]                   strobe_q, strobe_d;
    logic [RD_LATENCY-1:0]                 vld_q, err_q, vld_s, err_s;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_s;
    assign rd_hit = bus.rd_addr >= START_ADDR && bus.rd_addr < WIN_END[ADDR_WIDTH-1:0];
    assign wr_hit = bus.wr_addr >= START_ADDR && bus.wr_addr < WIN_END[ADDR_WIDTH-1:0];
    assign rd_idx = IW'(bus.rd_addr - START_ADDR);
    assign wr_idx = IW'(bus.wr_addr - START_ADDR);
    // pulse registers are write-only and read back as zero
    assign rd_val = rd_hit && !PULSE_MASK[rd_idx] ? reg_q[rd_idx] : '0;
    // stage inputs: entry 0 is the new request, entry i is stage i-1
    assign vld_s = RD_LATENCY'({vld_q, bus.rd_en});
    assign err_s = RD_LATENCY'({err_q, bus.rd_en && !rd_hit});
    assign dat_s = (RD_LATENCY*DATA_WIDTH)'({dat_q, rd_val});
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            strobe_d[i] = bus.wr_en && wr_hit && wr_idx == IW'(i);
            reg_d[i] = W1C_MASK[i] ? (reg_q[i] & ~(strobe_d[i] ? bus.wr_data : '0)) | status_set_i[i*DATA_WIDTH +: DATA_WIDTH]
                     : strobe_d[i] ? bus.wr_data : PULSE_MASK[i] ? '0 : reg_q[i];
            reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= (PULSE_MASK[i] || W1C_MASK[i]) ? '0 : RESET_VALUE;
            strobe_q <= '0;
            vld_q    <= '0;
            err_q    <= '0;
            dat_q    <= '0;
        end else begin
            reg_q    <= reg_d;
            strobe_q <= strobe_d;
            vld_q    <= vld_s;
            err_q    <= err_s;
            // data only moves with a valid so the output holds its last result
            for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= vld_s[i] ? dat_s[i] : dat_q[i];
        end
    end
    assign bus.rd_valid = vld_q[RD_LATENCY-1];
    assign bus.rd_err   = err_q[RD_LATENCY-1];
    assign bus.rd_data  = dat_q[RD_LATENCY-1];
    assign wr_strobe_o  = strobe_q;
endmodule

// File: tb/tb_mmio_reg_bank.sv
// tb_mmio_reg_bank: directed checks of four banks (RD_LATENCY 1..4) sharing one stimulus stream.
module tb_mmio_reg_bank;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         rd_en = 0, wr_en = 0;
    logic [15:0]  rd_addr = '0, wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic [511:0] status_set = '0;
    logic [63:0]  rd_data_w [4];
    logic         rd_valid_w [4];
    logic         rd_err_w [4];
    logic [511:0] reg_q_w [4];
    logic [7:0]   strobe_w [4];
    int           checks = 0, errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mmio_reg_bank_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) bus ();
        assign bus.rd_en   = rd_en;
        assign bus.rd_addr = rd_addr;
        assign bus.wr_en   = wr_en;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_data = wr_data;
        assign rd_data_w[g]  = bus.rd_data;
        assign rd_valid_w[g] = bus.rd_valid;
        assign rd_err_w[g]   = bus.rd_err;
        mmio_reg_bank #(
            .DATA_WIDTH(64), .ADDR_WIDTH(16), .START_ADDR(16'h0050), .NUM_REGS(8),
            .RD_LATENCY(g + 1), .PULSE_MASK(8'h01), .W1C_MASK(8'h02), .RESET_VALUE(64'hA5)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .status_set_i(status_set),
            .reg_q_o(reg_q_w[g]), .wr_strobe_o(strobe_w[g])
        );
    end
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic read_one(input logic [15:0] addr, input logic [63:0] exp_d, input logic exp_e);
        rd_en = 1;
        rd_addr = addr;
        tick();
        rd_en = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            for (int g = 0; g < 4; g++) begin
                check($sformatf("rd_valid L%0d a%h k%0d", g + 1, addr, k), 64'(rd_valid_w[g]), 64'(g + 1 == k));
                if (g + 1 == k) begin
                    check($sformatf("rd_data L%0d a%h", g + 1, addr), rd_data_w[g], exp_d);
                    check($sformatf("rd_err L%0d a%h", g + 1, addr), 64'(rd_err_w[g]), 64'(exp_e));
                end
            end
        end
    endtask
    initial begin
        tick();
        tick();
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst rd_valid L%0d", g + 1), 64'(rd_valid_w[g]), 0);
            check($sformatf("rst rd_data L%0d", g + 1), rd_data_w[g], 0);
            check($sformatf("rst rd_err L%0d", g + 1), 64'(rd_err_w[g]), 0);
            check($sformatf("rst strobe L%0d", g + 1), 64'(strobe_w[g]), 0);
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("rst reg%0d", i), reg_q_w[0][i*64 +: 64], i < 2 ? 64'h0 : 64'hA5);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1;
            rd_addr = 16'h0050 + 16'(i);
            tick();
            check($sformatf("rd all valid %0d", i), 64'(rd_valid_w[0]), 1);
            check($sformatf("rd all data %0d", i), rd_data_w[0], i < 2 ? 64'h0 : 64'hA5);
            check($sformatf("rd all err %0d", i), 64'(rd_err_w[0]), 0);
        end
        rd_en = 0;
        tick();
        check("rd all valid drop", 64'(rd_valid_w[0]), 0);
        check("rd all data hold", rd_data_w[0], 64'hA5);
        wr_en = 1;
        wr_addr = 16'h0052;
        wr_data = 64'hDEADBEEF;
        tick();
        wr_en = 0;
        check("rw reg2", reg_q_w[0][128 +: 64], 64'hDEADBEEF);
        check("rw strobe", 64'(strobe_w[0]), 64'h04);
        tick();
        check("rw strobe drop", 64'(strobe_w[0]), 0);
        check("rw reg2 hold", reg_q_w[0][128 +: 64], 64'hDEADBEEF);
        read_one(16'h0052, 64'hDEADBEEF, 0);
        wr_en = 1;
        wr_addr = 16'h0050;
        wr_data = 64'h5;
        tick();
        check("pulse reg0 c1", reg_q_w[0][0 +: 64], 64'h5);
        check("pulse strobe c1", 64'(strobe_w[0]), 64'h01);
        tick();
        wr_en = 0;
        check("pulse reg0 c2", reg_q_w[0][0 +: 64], 64'h5);
        check("pulse strobe c2", 64'(strobe_w[0]), 64'h01);
        tick();
        check("pulse reg0 c3", reg_q_w[0][0 +: 64], 64'h0);
        check("pulse strobe c3", 64'(strobe_w[0]), 0);
        read_one(16'h0050, 64'h0, 0);
        status_set[67] = 1;
        tick();
        status_set[67] = 0;
        check("w1c set", reg_q_w[0][64 +: 64], 64'h8);
        wr_en = 1;
        wr_addr = 16'h0051;
        wr_data = 64'h8;
        status_set[67] = 1;
        tick();
        wr_en = 0;
        status_set[67] = 0;
        check("w1c set wins", reg_q_w[0][64 +: 64], 64'h8);
        check("w1c strobe", 64'(strobe_w[0]), 64'h02);
        read_one(16'h0051, 64'h8, 0);
        wr_en = 1;
        tick();
        wr_en = 0;
        check("w1c clear", reg_q_w[0][64 +: 64], 64'h0);
        tick();
        rd_en = 1;
        rd_addr = 16'h0050;
        wr_en = 1;
        wr_addr = 16'h0058;
        wr_data = '1;
        tick();
        wr_en = 0;
        rd_addr = 16'h0058;
        check("miss wr strobe", 64'(strobe_w[1]), 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("miss wr reg%0d", i), reg_q_w[1][i*64 +: 64], i == 2 ? 64'hDEADBEEF : i < 2 ? 64'h0 : 64'hA5);
        check("b2b hold before", rd_data_w[1], 64'h8);
        tick();
        rd_addr = 16'h004F;
        check("b2b valid 50", 64'(rd_valid_w[1]), 1);
        check("b2b data 50", rd_data_w[1], 0);
        check("b2b err 50", 64'(rd_err_w[1]), 0);
        tick();
        rd_en = 0;
        check("b2b valid 58", 64'(rd_valid_w[1]), 1);
        check("b2b data 58", rd_data_w[1], 0);
        check("b2b err 58", 64'(rd_err_w[1]), 1);
        tick();
        check("b2b valid 4f", 64'(rd_valid_w[1]), 1);
        check("b2b data 4f", rd_data_w[1], 0);
        check("b2b err 4f", 64'(rd_err_w[1]), 1);
        tick();
        check("b2b valid end", 64'(rd_valid_w[1]), 0);
        check("b2b err end", 64'(rd_err_w[1]), 0);
        rd_en = 1;
        rd_addr = 16'h0052;
        tick();
        rd_addr = 16'h0053;
        tick();
        rd_en = 0;
        #2 rst_n = 0;
        #1;
        check("async rst reg2", reg_q_w[3][128 +: 64], 64'hA5);
        tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("flush valid k%0d", k), 64'(rd_valid_w[3]), 0);
            tick();
        end
        check("flush data", rd_data_w[3], 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("post rst reg%0d", i), reg_q_w[3][i*64 +: 64], i < 2 ? 64'h0 : 64'hA5);
        check("post rst strobe", 64'(strobe_w[3]), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_reg_bank.md
Name: mmio_reg_bank

Overview:
- Parametrised MMIO register bank on the user side of the MMIO link (hal drives rd/wr requests; this block returns read data).
- Next generation of the plain MMIO user endpoint. It adds the following:
  - address-window decode over NUM_REGS word registers;
  - per-register access modes: read/write, write-1-pulse, write-1-clear sticky status;
  - configurable read pipeline latency with an explicit rd_valid.
- Instantiated once per accelerator; register outputs feed the datapath controller.

Parameters:
- DATA_WIDTH, 64: register and bus width in bits.
- ADDR_WIDTH, 16: word address width.
- START_ADDR, 16'h0050: word address of register 0. The window is START_ADDR .. START_ADDR+NUM_REGS-1.
- NUM_REGS, 8: number of registers, 1..64.
- RD_LATENCY, 1: cycles from rd_en to rd_valid, legal range 1..4.
- PULSE_MASK, 0: bit i set makes register i write-1-pulse.
- W1C_MASK, 0: bit i set makes register i write-1-clear sticky status. PULSE_MASK & W1C_MASK must be 0; elaboration error otherwise.
- RESET_VALUE, 0: DATA_WIDTH reset value applied to every read/write register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request, one cycle per read.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse when rd_data is valid.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- status_set  in  NUM_REGS*DATA_WIDTH  per-bit set inputs for W1C registers; ignored for other registers.
- reg_q  out  NUM_REGS*DATA_WIDTH  current register contents. Register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- wr_strobe  out  NUM_REGS  one-cycle pulse, one cycle after an accepted write to register i.
- rd_err  out  1  one-cycle pulse, coincident with rd_valid, for an out-of-window read.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - reg_q: RESET_VALUE for read/write registers; 0 for pulse and W1C registers.
  - rd_data = 0, rd_valid = 0, rd_err = 0, wr_strobe = 0.
  - Read pipeline flushed.
- Address decode:
  - hit when START_ADDR <= addr < START_ADDR+NUM_REGS.
  - index = addr - START_ADDR, computed in ADDR_WIDTH bits.
  - Compare without overflow; a window reaching 2^ADDR_WIDTH is an elaboration error.
- Writes, accepted only on wr_en with a hit on wr_addr:
  - Read/write register: reg_q slice = wr_data on the next edge, held until the next write.
  - Pulse register: reg_q slice = wr_data for exactly one cycle, then 0. Back-to-back writes give consecutive pulses.
  - W1C register, per bit, every cycle: next = (cur & ~(wr_hit ? wr_data : 0)) | status_set. A set and a clear on the same bit in the same cycle leaves the bit at 1 (set wins).
  - wr_strobe[index] pulses one cycle after the accepted write, for all modes.
  - Miss: write dropped, no strobe, no other effect.
- Reads:
  - On rd_en, sample the selected register value (0 on a miss) at the rd_en edge; rd_addr must be valid on that same edge.
  - rd_valid and rd_data are presented exactly RD_LATENCY cycles after rd_en, through a RD_LATENCY-deep shift pipeline of {valid, err, data}.
  - A read in every cycle is supported: full throughput, one result per cycle, in order.
  - Pulse registers read as 0 (write-only).
  - A read and a write to the same register in the same cycle return the pre-write value.
  - Miss: rd_data = 0, rd_valid = 1, rd_err = 1.
  - rd_data holds its last valid value while rd_valid = 0.
- Simultaneous rd_en and wr_en to different or the same addresses: both are serviced independently in the same cycle.
- Reset mid-operation: in-flight reads are discarded (no rd_valid after release) and all registers return to reset values. The first request is accepted on the first clk edge with rst_n high.

Test Plan:
- Reset, then read all NUM_REGS=8 registers with RESET_VALUE=64'hA5 and RD_LATENCY=1 -> read/write registers return 64'hA5 one cycle after each rd_en; rd_valid is a 1-cycle pulse; rd_err=0.
- Write 64'hDEADBEEF to 16'h0052, then read 16'h0052 with RD_LATENCY=3 -> reg_q slice 2 = 64'hDEADBEEF one cycle after the write; wr_strobe=8'b0000_0100 for one cycle; rd_valid exactly 3 cycles after rd_en with the same data.
- PULSE_MASK=8'h01: write 64'h5 to 16'h0050 on two consecutive cycles, then read it -> reg_q slice 0 = 5 for two cycles, then 0; the read returns 0.
- W1C_MASK=8'h02: pulse status_set bit 3 on reg 1, then write 64'h8 to 16'h0051 in the same cycle as a new set on bit 3 -> bit 3 stays 1. A later write of 64'h8 with no set clears bit 3 to 0.
- Back-to-back reads to 16'h0050, 16'h0058 (miss) and 16'h004F (miss) with RD_LATENCY=2 -> three consecutive rd_valid pulses, in order. The last two return rd_data=0 with rd_err=1. A write to 16'h0058 changes no reg_q and gives no strobe.
- Assert rst_n low with two reads in flight (RD_LATENCY=4) -> no rd_valid after release, and all reg_q return to reset values.
